// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock, W steps per product.
// Produces the full 2W-bit product plus a W-bit saturated copy for the downstream adder.
module booth_seq_mult #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   prod,
  output logic [W-1:0]     prod_sat
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W:0]      r_m;
  logic [W:0]      r_a;
  logic [W-1:0]    r_q;
  logic            r_q_m1;
  logic [CW-1:0]   r_cnt;

  logic [W:0]      w_sum;
  logic [W:0]      w_a_sh;
  logic [W-1:0]    w_q_sh;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_sat;
  logic [W:0]      w_hi;
  logic            w_last;
  logic            w_accept;

  // Booth add/subtract on a W+1 bit accumulator so M = -2^(W-1) cannot overflow.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q_m1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
    w_a_sh = {w_sum[W], w_sum[W:1]};
    w_q_sh = {w_sum[0], r_q[W-1:1]};
    w_prod = {w_a_sh[W-1:0], w_q_sh};
    w_last = (r_cnt == CW'(W - 1));
  end

  // The product fits in W signed bits exactly when its top W+1 bits all match.
  always_comb begin
    w_hi = w_prod[2*W-1:W-1];
    if ((w_hi == '0) || (w_hi == '1)) begin
      w_sat = w_prod[W-1:0];
    end else if (w_prod[2*W-1]) begin
      w_sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      w_sat = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_a      <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      r_cnt    <= '0;
      prod     <= '0;
      prod_sat <= '0;
    end else if (w_accept) begin
      r_m    <= {a[W-1], a};
      r_q    <= b;
      r_a    <= '0;
      r_q_m1 <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a    <= w_a_sh;
      r_q    <= w_q_sh;
      r_q_m1 <= r_q[0];
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        prod     <= w_prod;
        prod_sat <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomised bench for booth_seq_mult (W=8): vector table, reset abort,
// back-to-back handshake and a reference-model sweep.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] prod;
  logic [W-1:0]  prod_sat;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] ep;
    logic [7:0]  es;
  } vec_t;

  vec_t vecs [13];

  booth_seq_mult #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .prod     (prod),
    .prod_sat (prod_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  // Launches one multiply and waits (bounded) for done; lat = edges after the accept edge.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb, output logic [15:0] p,
                         output logic [7:0] s, output int lat, output int busy_bad);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    starts++;
    lat = -1; busy_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_bad++;
    end
    p = prod; s = prod_sat;
  endtask

  function automatic logic [7:0] sat_ref(input logic signed [15:0] v);
    if (v > 16'sd127) return 8'h7F;
    if (v < -16'sd128) return 8'h80;
    return v[7:0];
  endfunction

  initial begin
    logic [15:0] p;
    logic [7:0]  s;
    int lat, bb, n, bad;
    logic signed [7:0] ra, rb;
    logic signed [15:0] rp;

    vecs[0]  = '{8'd5,    8'hFD, 16'hFFF1, 8'hF1};
    vecs[1]  = '{8'hF9,   8'hFA, 16'h002A, 8'h2A};
    vecs[2]  = '{8'h80,   8'h80, 16'h4000, 8'h7F};
    vecs[3]  = '{8'h80,   8'h7F, 16'hC080, 8'h80};
    vecs[4]  = '{8'h7F,   8'h7F, 16'h3F01, 8'h7F};
    vecs[5]  = '{8'h00,   8'hFF, 16'h0000, 8'h00};
    vecs[6]  = '{8'hFF,   8'h01, 16'hFFFF, 8'hFF};
    vecs[7]  = '{8'd11,   8'h01, 16'h000B, 8'h0B};
    vecs[8]  = '{8'd100,  8'hFE, 16'hFF38, 8'h80};
    vecs[9]  = '{8'hFF,   8'hFF, 16'h0001, 8'h01};
    vecs[10] = '{8'd16,   8'd8,  16'h0080, 8'h7F};
    vecs[11] = '{8'hF0,   8'd8,  16'hFF80, 8'h80};
    vecs[12] = '{8'h7F,   8'h01, 16'h007F, 8'h7F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prod", 32'(prod), 0);
    chk("rst_sat",  32'(prod_sat), 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-multiply aborts without a done pulse
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_prod", 32'(prod), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 0);
    chk("abort_prod_hold", 32'(prod), 0);
    done_cnt = 0;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_mult(vecs[i].va, vecs[i].vb, p, s, lat, bb);
      $display("vec %0d a=%0d b=%0d prod=0x%04h sat=0x%02h lat=%0d", i,
               $signed(vecs[i].va), $signed(vecs[i].vb), p, s, lat);
      chk($sformatf("vec%0d_prod", i), 32'(p), 32'(vecs[i].ep));
      chk($sformatf("vec%0d_sat", i), 32'(s), 32'(vecs[i].es));
      chk($sformatf("vec%0d_latency", i), 32'(lat), W);
      chk($sformatf("vec%0d_busy", i), 32'(bb), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
    end

    // Back-to-back: start held through busy is only taken on the DONE-cycle edge
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd4;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd9;
    starts++;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    $display("hs first prod=0x%04h lat=%0d", prod, lat);
    chk("hs_first_prod", 32'(prod), 32'h000C);
    chk("hs_first_lat", 32'(lat), W);
    @(posedge clk); #1;
    start = 1'b0;
    starts++;
    chk("hs_accept_busy", 32'(busy), 1);
    lat = -1; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (prod !== 16'h000C) bad++;
    end
    $display("hs second prod=0x%04h lat=%0d", prod, lat);
    chk("hs_prod_stable", 32'(bad), 0);
    chk("hs_second_prod", 32'(prod), 32'h0051);
    chk("hs_second_lat", 32'(lat), W);

    // Randomised sweep against a behavioural reference
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rp = 16'(ra) * 16'(rb);
      do_mult(ra, rb, p, s, lat, bb);
      if (p !== rp || s !== sat_ref(rp) || lat != W) begin
        bad++;
        $display("FAIL rand a=%0d b=%0d prod=0x%04h/0x%04h sat=0x%02h/0x%02h lat=%0d",
                 ra, rb, p, rp, s, sat_ref(rp), lat);
      end
    end
    $display("rand sweep 1000 pairs, %0d bad", bad);
    chk("rand_bad", 32'(bad), 0);
    @(posedge clk); #1;
    chk("done_count", 32'(done_cnt), 32'(starts));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
